// File: rtl/cluster_point_feeder_pkg.sv
// Shared definitions for the cluster point feeder and its consumer
// (Calculation_center): default widths and FSM state encodings.
package cluster_point_feeder_pkg;

    // Default coordinate width and point-count width.
    localparam int COOR_W_DEF = 9;
    localparam int Q_W_DEF    = 7;

    // Feeder FSM states. The encoding is fixed so the consumer can decode
    // a mirrored copy of the state if it ever needs to.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ANNOUNCE = 3'd1,
        ST_SEND     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_FINISH   = 3'd4
    } feeder_state_e;

    // Pack one point into a single buffer word, X in the upper half.
    function automatic logic [2*COOR_W_DEF-1:0] pack_point(
        input logic [COOR_W_DEF-1:0] x,
        input logic [COOR_W_DEF-1:0] y
    );
        return {x, y};
    endfunction

endpackage

// File: rtl/point_buffer_ram.sv
// Simple dual-port point buffer: synchronous write, registered read.
// Contents are never reset; the feeder only reads addresses it wrote.
module point_buffer_ram #(
    parameter int AW = 7,
    parameter int DW = 18
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rd_data_q;

    // Write port plus always-enabled registered read port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cluster_point_feeder.sv
// Buffers a cluster of (X,Y) points while idle, then on start announces
// the point count and streams the points out one per cycle, pausing
// whenever the downstream busy flag is high.
module cluster_point_feeder
    import cluster_point_feeder_pkg::*;
#(
    parameter int COOR_W = COOR_W_DEF,
    parameter int Q_W    = Q_W_DEF
) (
    input  logic              Feeder_clk,
    input  logic              Feeder_rst,
    input  logic              wrEn,
    input  logic [COOR_W-1:0] wrX,
    input  logic [COOR_W-1:0] wrY,
    input  logic              start,
    input  logic              tranFlagOUT,
    output logic [Q_W-1:0]    coorQ,
    output logic [COOR_W-1:0] coorX,
    output logic [COOR_W-1:0] coorY,
    output logic              coorValid,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    // Buffer holds 2**Q_W-1 points so the count always fits in Q_W bits.
    localparam logic [Q_W-1:0] FULL_CNT = {Q_W{1'b1}};

    feeder_state_e     state_q, state_d;
    logic [Q_W-1:0]    wr_count_q, wr_count_d;
    logic [Q_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [Q_W-1:0]    cnt_q, cnt_d;
    logic [COOR_W-1:0] x_q, x_d;
    logic [COOR_W-1:0] y_q, y_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic                ram_we;
    logic [2*COOR_W-1:0] ram_rdata;
    logic [COOR_W-1:0]   rd_x, rd_y;

    // The RAM is addressed with the next read pointer, so its registered
    // output always holds buffer[rd_ptr_q]; this prefetch lets a point be
    // taken on every cycle without a read bubble.
    point_buffer_ram #(
        .AW (Q_W),
        .DW (2*COOR_W)
    ) u_buf (
        .clk_i     (Feeder_clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_count_q),
        .wr_data_i ({wrX, wrY}),
        .rd_addr_i (rd_ptr_d),
        .rd_data_o (ram_rdata)
    );

    assign rd_x = ram_rdata[2*COOR_W-1:COOR_W];
    assign rd_y = ram_rdata[COOR_W-1:0];

    // Next-state and output logic for the load / announce / stream sequence.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        ram_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A write in the start cycle is counted before the count
                // is latched for the announcement.
                if (wrEn) begin
                    if (wr_count_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_we     = 1'b1;
                        wr_count_d = wr_count_q + 1'b1;
                    end
                end
                if (start) begin
                    state_d = ST_ANNOUNCE;
                    cnt_d   = wr_count_d;
                end
            end

            ST_ANNOUNCE: begin
                state_d = (wr_count_q == '0) ? ST_FINISH : ST_SEND;
            end

            ST_SEND, ST_HOLD: begin
                // HOLD resumes on the same edge the flag drops, so the
                // frozen point is followed immediately by the next one.
                if (tranFlagOUT) begin
                    state_d = ST_HOLD;
                end else begin
                    x_d      = rd_x;
                    y_d      = rd_y;
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = (rd_ptr_d == wr_count_q) ? ST_FINISH : ST_SEND;
                end
            end

            ST_FINISH: begin
                done_d     = 1'b1;
                wr_count_d = '0;
                rd_ptr_d   = '0;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in progress.
    always_ff @(posedge Feeder_clk) begin
        if (!Feeder_rst) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign coorQ     = cnt_q;
    assign coorX     = x_q;
    assign coorY     = y_q;
    assign coorValid = valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cluster_point_feeder.sv
// Scoreboard bench for cluster_point_feeder: a queue-based model of the
// buffer produces the expected point stream, a negedge monitor checks it.
module tb_cluster_point_feeder;

    localparam int CW    = 9;
    localparam int QW    = 7;
    localparam int DEPTH = 127;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [CW-1:0] wr_x, wr_y;
    logic          start;
    logic          flag;
    logic [QW-1:0] coorQ;
    logic [CW-1:0] coorX, coorY;
    logic          coorValid, busy, done, overflow;

    always #5 clk = ~clk;

    cluster_point_feeder #(.COOR_W(CW), .Q_W(QW)) dut (
        .Feeder_clk  (clk),
        .Feeder_rst  (rst_n),
        .wrEn        (wr_en),
        .wrX         (wr_x),
        .wrY         (wr_y),
        .start       (start),
        .tranFlagOUT (flag),
        .coorQ       (coorQ),
        .coorX       (coorX),
        .coorY       (coorY),
        .coorValid   (coorValid),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*CW-1:0] model_buf[$];
    logic [2*CW-1:0] exp_q[$];
    int              exp_cnt   = 0;
    bit              model_ovf = 1'b0;
    int              done_seen = 0;
    logic            flag_at_edge = 1'b0;
    logic            busy_at_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model of the buffer: store while not full, else flag overflow.
    function automatic void model_write(input logic [CW-1:0] x, input logic [CW-1:0] y);
        if (model_buf.size() < DEPTH) model_buf.push_back({x, y});
        else model_ovf = 1'b1;
    endfunction

    function automatic void model_start();
        exp_q   = model_buf;
        exp_cnt = model_buf.size();
        model_buf.delete();
    endfunction

    // Remember what the DUT saw at each active edge for the backpressure check.
    always @(posedge clk) begin
        flag_at_edge <= flag;
        busy_at_edge <= busy;
    end

    // Monitor: every presented point must be the next expected one.
    always @(negedge clk) begin
        logic [2*CW-1:0] pt;
        if (rst_n === 1'b1) begin
            if (busy_at_edge && flag_at_edge) check("hold_no_valid", coorValid, 0);
            if (coorValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_point", 1, 0);
                end else begin
                    pt = exp_q.pop_front();
                    $display("point (%0d,%0d) expected (%0d,%0d) coorQ=%0d",
                             coorX, coorY, pt[2*CW-1:CW], pt[CW-1:0], coorQ);
                    check("point_x", coorX, pt[2*CW-1:CW]);
                    check("point_y", coorY, pt[CW-1:0]);
                    check("coorQ_hold", coorQ, exp_cnt);
                end
            end
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic write_pt(input logic [CW-1:0] x, input logic [CW-1:0] y, input bit with_start);
        wr_en = 1'b1; wr_x = x; wr_y = y; start = with_start;
        model_write(x, y);
        if (with_start) model_start();
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        model_start();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_announce();
        @(negedge clk);
        check("announce_coorQ", coorQ, exp_cnt);
        check("announce_valid", coorValid, 0);
        check("announce_busy", busy, 1);
    endtask

    task automatic wait_done(input int flag_pct, input bit inject_wr);
        bit got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            flag  = ($urandom_range(0, 99) < flag_pct);
            wr_en = inject_wr && busy && ($urandom_range(0, 1) == 1);
            wr_x  = CW'($urandom);
            wr_y  = CW'($urandom);
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        flag = 1'b0; wr_en = 1'b0;
        check("done_seen", got, 1);
        check("all_points_delivered", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("coorQ_cleared", coorQ, 0);
    endtask

    task automatic load_ref5(input bit last_with_start);
        write_pt(9'd53, 9'd17, 1'b0);
        write_pt(9'd14, 9'd245, 1'b0);
        write_pt(9'd107, 9'd43, 1'b0);
        write_pt(9'd64, 9'd8, 1'b0);
        write_pt(9'd62, 9'd345, last_with_start);
    endtask

    // Wait until the n-th point of the current transfer is on the outputs.
    task automatic wait_points(input int n);
        int seen = 0;
        for (int c = 0; c < 200 && seen < n; c++) begin
            @(negedge clk);
            if (coorValid === 1'b1) seen++;
        end
        check("points_reached", seen, n);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; start = 1'b0; flag = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_coorQ", coorQ, 0);
        check("rst_coorX", coorX, 0);
        check("rst_coorY", coorY, 0);
        check("rst_valid", coorValid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reference cluster, no backpressure.
        load_ref5(1'b0);
        do_start();
        check_announce();
        wait_done(0, 1'b0);

        // Reference cluster, downstream busy for 3 cycles after the 2nd point.
        load_ref5(1'b0);
        do_start();
        check_announce();
        wait_points(2);
        flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", coorValid, 0);
            check("hold_x_frozen", coorX, 14);
            check("hold_y_frozen", coorY, 245);
        end
        flag = 1'b0;
        wait_done(0, 1'b0);

        // Empty cluster.
        do_start();
        check_announce();
        wait_done(0, 1'b0);

        // Writes during transmission are ignored; last load shares the start cycle.
        load_ref5(1'b1);
        check_announce();
        wait_done(0, 1'b1);

        // Random clusters with random backpressure.
        for (int k = 0; k < 4; k++) begin
            int n = $urandom_range(1, 20);
            bit ws = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++)
                write_pt(CW'($urandom), CW'($urandom), ws && (i == n - 1));
            if (!ws) do_start();
            check_announce();
            wait_done(30, k[0]);
        end

        // Overflow: 128 writes, only 127 stored.
        for (int i = 0; i < DEPTH; i++) write_pt(CW'($urandom), CW'($urandom), 1'b0);
        @(negedge clk);
        check("no_overflow_at_127", overflow, 0);
        @(posedge clk); #1;
        write_pt(CW'($urandom), CW'($urandom), 1'b0);
        @(negedge clk);
        check("overflow_set", overflow, model_ovf);
        @(posedge clk); #1;
        do_start();
        check_announce();
        wait_done(20, 1'b0);
        check("overflow_sticky", overflow, 1);

        // Reset after the 3rd point aborts the transfer without a done pulse.
        @(posedge clk); #1;
        load_ref5(1'b0);
        do_start();
        check_announce();
        wait_points(3);
        d0 = done_seen;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_coorQ", coorQ, 0);
        check("abort_coorX", coorX, 0);
        check("abort_coorY", coorY, 0);
        check("abort_valid", coorValid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_overflow", overflow, 0);
        exp_q.delete(); model_buf.delete(); model_ovf = 1'b0; exp_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_seen, d0);
        write_pt(9'd300, 9'd1, 1'b0);
        write_pt(9'd2, 9'd511, 1'b0);
        do_start();
        check_announce();
        wait_done(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_point_feeder.md
CLUSTER_POINT_FEEDER -- requirements
Module: cluster_point_feeder

Interface
REQ-001 SHALL have parameter COOR_W, default 9: coordinate width.
REQ-002 SHALL have parameter Q_W, default 7: point-count width; buffer depth is 2**Q_W-1 = 127 points.
REQ-003 SHALL have port Feeder_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port Feeder_rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port wrEn, input, 1: load one point into the buffer this cycle.
REQ-006 SHALL have port wrX, input, COOR_W: X coordinate of the loaded point.
REQ-007 SHALL have port wrY, input, COOR_W: Y coordinate of the loaded point.
REQ-008 SHALL have port start, input, 1: single-cycle pulse that begins transmission of the buffered cluster.
REQ-009 SHALL have port tranFlagOUT, input, 1: busy/backpressure flag from Calculation_center; high means hold.
REQ-010 SHALL have port coorQ, output, Q_W: number of points in the cluster being sent.
REQ-011 SHALL have port coorX, output, COOR_W: current point X.
REQ-012 SHALL have port coorY, output, COOR_W: current point Y.
REQ-013 SHALL have port coorValid, output, 1: coorX/coorY hold a new point this cycle.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the last point is accepted.
REQ-016 SHALL have port overflow, output, 1: sticky; a write was dropped because the buffer was full.

Function
REQ-017 SHALL implement the FSM states IDLE, ANNOUNCE, SEND, HOLD and FINISH.
REQ-018 IDLE SHALL accept wrEn writes at address wrCount, then increment wrCount; it SHALL ignore writes when wrCount = 127 and set overflow.
REQ-019 wrEn SHALL be ignored outside IDLE.
REQ-020 When wrEn and start are asserted in the same cycle, the write SHALL be stored and counted before the start is processed.
REQ-021 On start in IDLE, the block SHALL move to ANNOUNCE in the next cycle.
REQ-022 In ANNOUNCE, coorQ SHALL equal wrCount for exactly one cycle and coorValid SHALL be 0.
REQ-023 coorQ SHALL then hold that value until FINISH.
REQ-024 ANNOUNCE SHALL go to SEND, or directly to FINISH if wrCount = 0.
REQ-025 In SEND, each cycle with tranFlagOUT = 0 SHALL present buffer[rdPtr] on coorX/coorY, set coorValid = 1 and increment rdPtr.
REQ-026 Buffer reads SHALL be registered, with one-cycle read latency absorbed by prefetch, so that back-to-back points appear on consecutive cycles.
REQ-027 When tranFlagOUT = 1 in SEND, the FSM SHALL enter HOLD: coorX/coorY frozen, coorValid = 0, rdPtr frozen.
REQ-028 HOLD SHALL return to SEND on the first cycle tranFlagOUT = 0, with no point lost or duplicated.
REQ-029 After the point at rdPtr = wrCount-1 is presented, the FSM SHALL go to FINISH.
REQ-030 FINISH SHALL pulse done for one cycle, clear wrCount, rdPtr and coorQ, and return to IDLE.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 Pointers SHALL be Q_W bits wide and never wrap; the full condition is wrCount = 127.

Reset
REQ-033 When Feeder_rst = 0 at a clock edge, the block SHALL force state IDLE, wrCount = rdPtr = 0, coorQ = 0, coorX = coorY = 0, coorValid = 0, busy = 0, done = 0 and overflow = 0.
REQ-034 Reset asserted mid-transmission SHALL abort it; no done pulse SHALL be issued.
REQ-035 Buffer contents SHALL NOT be reset and are treated as invalid after reset.

Structure
REQ-036 A shared package SHALL hold the FSM state encodings and the COOR_W/Q_W defaults, shared with Calculation_center.
REQ-037 The buffer SHALL be one sub-module, point_buffer_ram: simple dual-port, 128 x (2*COOR_W), synchronous write, registered read.

Verification
REQ-038 Load (53,17), (14,245), (107,43), (64,8), (62,345), start, tranFlagOUT = 0 -> coorQ = 5 one cycle after start; points appear in order on 5 consecutive cycles with coorValid = 1; done pulses one cycle later.
REQ-039 Same load, tranFlagOUT held high for 3 cycles after the 2nd point -> the 2nd point stays frozen, coorValid = 0 for 3 cycles; resumes with (107,43); all 5 delivered exactly once.
REQ-040 start with no points loaded -> coorQ = 0 in ANNOUNCE; coorValid never asserted; done pulses on the next cycle.
REQ-041 128 writes -> first 127 stored, overflow = 1; transmission sends coorQ = 127 points.
REQ-042 Feeder_rst = 0 after the 3rd point -> all outputs 0 next cycle, no done; a new load of 2 points plus start -> coorQ = 2, clean transfer.
REQ-043 wrEn issued during SEND -> ignored; coorQ and the point sequence are unchanged.
